// File: rtl/act_pingpong_buffer_pkg.sv
// Shared defaults and bank-state encoding for the double-buffered activation gatherer.
package act_pingpong_buffer_pkg;
    localparam int ACT_DATA_W = 32;
    localparam int ACT_WORDS  = 9;
    localparam int ACT_IDX_W  = 8;

    typedef enum logic [1:0] {
        BANK_FILL = 2'd0,
        BANK_FULL = 2'd1,
        BANK_OUT  = 2'd2
    } bank_state_e;
endpackage

// File: rtl/act_pingpong_buffer_bank.sv
// One activation bank: WORDS data registers plus a written mask; exposes the
// post-write vector and full flag so the top can swap on the completing write.
module act_bank
    import act_pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int WORDS  = ACT_WORDS,
    parameter int IDX_W  = ACT_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    mask_clr,
    input  logic                    wr,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       wdat,
    output logic [DATA_W*WORDS-1:0] vec_next,
    output logic                    full,
    output logic                    full_next
);
    logic [DATA_W-1:0] data_q [WORDS];
    logic [DATA_W-1:0] data_d [WORDS];
    logic [WORDS-1:0]  mask_q;
    logic [WORDS-1:0]  hit;

    // Word 0 lands in the most significant slice of the vector.
    always_comb begin
        vec_next = '0;
        hit      = '0;
        data_d   = data_q;
        for (int k = 0; k < WORDS; k++) begin
            hit[k]    = wr && (int'(idx) == k);
            data_d[k] = hit[k] ? wdat : data_q[k];
            vec_next[DATA_W*(WORDS-k)-1 -: DATA_W] = data_d[k];
        end
    end

    assign full      = &mask_q;
    assign full_next = &(mask_q | hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '{default: '0};
            mask_q <= '0;
        end else if (flush) begin
            data_q <= '{default: '0};
            mask_q <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_clr ? '0 : (mask_q | hit);
        end
    end
endmodule

// File: rtl/act_pingpong_buffer.sv
// Ping-pong activation buffer: bus fills one bank while the other is presented on o_data.
// Vector valid one edge after its last word; write side stalls only when both banks are busy.
module act_pingpong_buffer
    import act_pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int WORDS  = ACT_WORDS,
    parameter int IDX_W  = ACT_IDX_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_clear,
    input  logic                    i_wr_en,
    input  logic                    i_wr_auto,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_wr_ready,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_W*WORDS-1:0] o_data,
    output logic                    o_idx_err
);
    logic                    fill_sel;
    logic [IDX_W-1:0]        wr_ptr;
    logic [IDX_W-1:0]        wr_idx;
    logic                    idx_ok;
    logic                    accept;
    logic                    consume;
    logic                    swap;
    logic [1:0]              bank_wr;
    logic [1:0]              bank_clr;
    logic [1:0]              full;
    logic [1:0]              full_next;
    logic [DATA_W*WORDS-1:0] vec_next [2];
    bank_state_e             state [2];

    assign wr_idx  = i_wr_auto ? wr_ptr : i_wr_idx;
    assign idx_ok  = int'(wr_idx) < WORDS;
    assign accept  = i_wr_en && o_wr_ready;
    assign consume = o_out_valid && i_out_ready;

    // The non-fill bank is OUT exactly while its copy sits valid in the output register.
    always_comb begin
        state[0] = BANK_FILL;
        state[1] = BANK_FILL;
        for (int b = 0; b < 2; b++) begin
            if (b != int'(fill_sel))
                state[b] = o_out_valid ? BANK_OUT : BANK_FILL;
            else
                state[b] = full[b] ? BANK_FULL : BANK_FILL;
        end
    end

    assign o_wr_ready = !(state[fill_sel] == BANK_FULL && state[~fill_sel] == BANK_OUT);

    // Swap is decided on the post-write mask so the completing word is not delayed a cycle.
    assign swap = !i_clear && full_next[fill_sel] &&
                  (state[~fill_sel] != BANK_OUT || consume);

    always_comb begin
        bank_wr             = '0;
        bank_clr            = '0;
        bank_wr[fill_sel]   = accept && idx_ok && !i_clear;
        bank_clr[~fill_sel] = swap;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        act_bank #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk       (CLK),
            .rst       (RST),
            .flush     (i_clear),
            .mask_clr  (bank_clr[b]),
            .wr        (bank_wr[b]),
            .idx       (wr_idx),
            .wdat      (i_data),
            .vec_next  (vec_next[b]),
            .full      (full[b]),
            .full_next (full_next[b])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_sel    <= 1'b0;
            wr_ptr      <= '0;
            o_out_valid <= 1'b0;
            o_data      <= '0;
            o_idx_err   <= 1'b0;
        end else if (i_clear) begin
            fill_sel    <= 1'b0;
            wr_ptr      <= '0;
            o_out_valid <= 1'b0;
            o_data      <= '0;
            o_idx_err   <= 1'b0;
        end else begin
            if (swap) begin
                o_data      <= vec_next[fill_sel];
                o_out_valid <= 1'b1;
                fill_sel    <= ~fill_sel;
            end else if (consume) begin
                o_out_valid <= 1'b0;
            end
            if (accept && !idx_ok)
                o_idx_err <= 1'b1;
            if (bank_wr[fill_sel] && full_next[fill_sel])
                wr_ptr <= '0;
            else if (bank_wr[fill_sel] && i_wr_auto)
                wr_ptr <= wr_ptr + IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Bench for act_pingpong_buffer: table of auto-fill vectors, directed corner sequences,
// then random traffic against a queue-based transaction model.
module tb_act_pingpong_buffer;
    localparam int DW = 32;
    localparam int NW = 9;
    localparam int IW = 8;
    localparam int VW = DW * NW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_clear = 1'b0;
    logic          i_wr_en = 1'b0;
    logic          i_wr_auto = 1'b0;
    logic [IW-1:0] i_wr_idx = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_out_ready = 1'b0;
    logic          o_wr_ready;
    logic          o_out_valid;
    logic          o_idx_err;
    logic [VW-1:0] o_data;

    always #5 CLK = ~CLK;

    act_pingpong_buffer #(.DATA_W(DW), .WORDS(NW), .IDX_W(IW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_clear     (i_clear),
        .i_wr_en     (i_wr_en),
        .i_wr_auto   (i_wr_auto),
        .i_wr_idx    (i_wr_idx),
        .i_data      (i_data),
        .o_wr_ready  (o_wr_ready),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_data      (o_data),
        .o_idx_err   (o_idx_err)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: a partial vector, a queue of completed vectors, and the shown vector.
    logic [DW-1:0] m_word [NW];
    bit            m_mask [NW];
    int            m_ptr;
    bit            m_err;
    bit            m_vld;
    logic [VW-1:0] m_out;
    logic [VW-1:0] m_pend [$];

    function automatic void model_reset();
        for (int k = 0; k < NW; k++) begin
            m_word[k] = '0;
            m_mask[k] = 1'b0;
        end
        m_ptr = 0;
        m_err = 1'b0;
        m_vld = 1'b0;
        m_out = '0;
        m_pend.delete();
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v = '0;
        for (int k = 0; k < NW; k++) v = (v << DW) | VW'(m_word[k]);
        return v;
    endfunction

    function automatic void model_step(input bit clr, input bit en, input bit au,
                                       input logic [IW-1:0] idx, input logic [DW-1:0] d,
                                       input bit ordy);
        bit consumed;
        bit all_set;
        int i;
        if (clr) begin
            model_reset();
            return;
        end
        consumed = m_vld && ordy;
        if (en && m_pend.size() == 0) begin
            i = au ? m_ptr : int'(idx);
            if (i >= NW) begin
                m_err = 1'b1;
            end else begin
                m_word[i] = d;
                m_mask[i] = 1'b1;
                if (au) m_ptr++;
                all_set = 1'b1;
                for (int k = 0; k < NW; k++) all_set &= m_mask[k];
                if (all_set) begin
                    m_pend.push_back(model_vec());
                    for (int k = 0; k < NW; k++) m_mask[k] = 1'b0;
                    m_ptr = 0;
                end
            end
        end
        if (consumed) m_vld = 1'b0;
        if (!m_vld && m_pend.size() > 0) begin
            m_out = m_pend.pop_front();
            m_vld = 1'b1;
        end
    endfunction

    function automatic bit model_rdy();
        return m_pend.size() == 0;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic cyc(input bit clr, input bit en, input bit au, input logic [IW-1:0] idx,
                       input logic [DW-1:0] d, input bit ordy);
        i_clear     = clr;
        i_wr_en     = en;
        i_wr_auto   = au;
        i_wr_idx    = idx;
        i_data      = d;
        i_out_ready = ordy;
        model_step(clr, en, au, idx, d, ordy);
        @(posedge CLK);
        #1;
        chk("model_valid", VW'(o_out_valid), VW'(m_vld));
        chk("model_ready", VW'(o_wr_ready), VW'(model_rdy()));
        chk("model_err",   VW'(o_idx_err), VW'(m_err));
        chk("model_data",  o_data, m_out);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    function automatic logic [VW-1:0] seq_vec(input logic [DW-1:0] base);
        logic [VW-1:0] v = '0;
        for (int k = 0; k < NW; k++) v = (v << DW) | VW'(base + DW'(k));
        return v;
    endfunction

    typedef struct {
        bit            en;
        bit            au;
        logic [DW-1:0] d;
        bit            ordy;
        bit            e_vld;
        bit            e_rdy;
        bit            e_err;
        logic [VW-1:0] e_data;
    } row_t;

    row_t          tbl [10];
    logic [VW-1:0] exp2;
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;

    initial begin
        // Auto fill 0x11111111*k, k=1..9, then one consume.
        exp2 = '0;
        for (int k = 1; k <= 9; k++) exp2 = (exp2 << DW) | VW'(DW'(32'h11111111 * k));
        for (int k = 1; k <= 9; k++) begin
            tbl[k-1].en     = 1'b1;
            tbl[k-1].au     = 1'b1;
            tbl[k-1].d      = DW'(32'h11111111 * k);
            tbl[k-1].ordy   = 1'b0;
            tbl[k-1].e_vld  = (k == 9);
            tbl[k-1].e_rdy  = 1'b1;
            tbl[k-1].e_err  = 1'b0;
            tbl[k-1].e_data = (k == 9) ? exp2 : '0;
        end
        tbl[9].en     = 1'b0;
        tbl[9].au     = 1'b0;
        tbl[9].d      = '0;
        tbl[9].ordy   = 1'b1;
        tbl[9].e_vld  = 1'b0;
        tbl[9].e_rdy  = 1'b1;
        tbl[9].e_err  = 1'b0;
        tbl[9].e_data = exp2;

        model_reset();
        #1;
        chk("rst_valid", VW'(o_out_valid), VW'(1'b0));
        chk("rst_data",  o_data, '0);
        chk("rst_ready", VW'(o_wr_ready), VW'(1'b1));
        chk("rst_err",   VW'(o_idx_err), VW'(1'b0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int r = 0; r < 10; r++) begin
            cyc(1'b0, tbl[r].en, tbl[r].au, '0, tbl[r].d, tbl[r].ordy);
            chk("tbl_valid", VW'(o_out_valid), VW'(tbl[r].e_vld));
            chk("tbl_ready", VW'(o_wr_ready), VW'(tbl[r].e_rdy));
            chk("tbl_err",   VW'(o_idx_err), VW'(tbl[r].e_err));
            chk("tbl_data",  o_data, tbl[r].e_data);
        end
        chk("auto_ms_word", VW'(o_data[287:256]), VW'(32'h11111111));
        chk("auto_ls_word", VW'(o_data[31:0]), VW'(32'h99999999));

        // Async reset mid-fill with a sticky error and a held nonzero o_data.
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'h77000000 + n), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'd12, 32'h0BAD0BAD, 1'b0);
        chk("pre_rst_err", VW'(o_idx_err), VW'(1'b1));
        #2 RST = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", VW'(o_out_valid), VW'(1'b0));
        chk("arst_data",  o_data, '0);
        chk("arst_ready", VW'(o_wr_ready), VW'(1'b1));
        chk("arst_err",   VW'(o_idx_err), VW'(1'b0));
        #1 RST = 1'b0;

        // Explicit indices 8..0 with a stray index 9 in the middle.
        for (int i = 8; i >= 0; i--) begin
            cyc(1'b0, 1'b1, 1'b0, IW'(i), DW'(32'hA5000000 + i), 1'b0);
            if (i == 4) cyc(1'b0, 1'b1, 1'b0, 8'd9, 32'hDEADBEEF, 1'b0);
        end
        chk("expl_valid", VW'(o_out_valid), VW'(1'b1));
        chk("expl_data",  o_data, seq_vec(32'hA5000000));
        chk("expl_err",   VW'(o_idx_err), VW'(1'b1));
        idle(1'b1);

        // Two vectors queued with no consumer: backpressure after the 18th word.
        for (int n = 0; n < 18; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hB0000000 + n), 1'b0);
        v1 = seq_vec(32'hB0000000);
        v2 = seq_vec(32'hB0000009);
        chk("bp_ready_low", VW'(o_wr_ready), VW'(1'b0));
        cyc(1'b0, 1'b1, 1'b1, '0, 32'hCAFEF00D, 1'b0);
        chk("bp_hold_data", o_data, v1);
        idle(1'b1);
        chk("bp_ready_up", VW'(o_wr_ready), VW'(1'b1));
        chk("bp_valid",    VW'(o_out_valid), VW'(1'b1));
        chk("bp_second",   o_data, v2);
        idle(1'b1);
        chk("bp_drained", VW'(o_out_valid), VW'(1'b0));

        // Last word of B lands in the same cycle A is consumed.
        for (int n = 0; n < 9; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hC0000000 + n), 1'b0);
        for (int n = 0; n < 8; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hD0000000 + n), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, '0, 32'hD0000008, 1'b1);
        chk("simul_valid", VW'(o_out_valid), VW'(1'b1));
        chk("simul_data",  o_data, seq_vec(32'hD0000000));
        idle(1'b1);

        // Clear with a vector shown and a partial fill; clear beats the write and consume.
        for (int n = 0; n < 9; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hE0000000 + n), 1'b0);
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hE1000000 + n), 1'b0);
        cyc(1'b1, 1'b1, 1'b1, '0, 32'h12345678, 1'b1);
        chk("clr_valid", VW'(o_out_valid), VW'(1'b0));
        chk("clr_data",  o_data, '0);
        chk("clr_ready", VW'(o_wr_ready), VW'(1'b1));
        chk("clr_err",   VW'(o_idx_err), VW'(1'b0));
        for (int n = 0; n < 9; n++) cyc(1'b0, 1'b1, 1'b1, '0, DW'(32'hF0000000 + n), 1'b0);
        chk("clr_fresh", o_data, seq_vec(32'hF0000000));
        idle(1'b1);

        // Random traffic: mixed auto/explicit writes, bad indices, sporadic consume and clear.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 3) != 0,
                IW'($urandom_range(0, 11)),
                DW'($urandom),
                $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
